mc_sequencer: RTL
=================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles to wait for MemReady before halting.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 OpCode  input  6  instruction opcode from the instruction register output.
REQ-005 Zero  input  1  ALU result == 0.
REQ-006 Greater  input  1  ALU first operand > second operand.
REQ-007 MemReady  input  1  memory completes the current read/write this cycle.
REQ-008 PCWrite, IRWrite, IorD  output  1 each  PC load, IR load, memory address select (0=PC, 1=ALU).
REQ-009 RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, BranchEq, BranchGr, Jump, ExtOp  output  1 each  datapath controls.
REQ-010 AluOp  output  3  ALU operation select.
REQ-011 Halted  output  1  sequencer stopped (illegal opcode or memory timeout).
REQ-012 Err  output  2  halt cause: 00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout.
REQ-013 InstrCount  output  16  retired-instruction counter.
REQ-014 State  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

Function
REQ-015 Opcode map SHALL be: 000000 R-type, 000001 addi, 000010 ori, 000011 andi, 000100 lw, 000101 sw, 000110 beq, 000111 bgt, 001000 jump; all other values are illegal.
REQ-016 OpCode SHALL be latched into an internal register on the DECODE cycle; EXEC/MEM/WB outputs derive from the latched value only.
REQ-017 Outputs not listed as asserted in a state SHALL be 0 in that state.
REQ-018 IDLE: no outputs asserted; next state is FETCH.
REQ-019 FETCH: MemRead=1, IorD=0, AluOp=2; when MemReady=1, IRWrite=1 and PCWrite=1 in that cycle, next state is DECODE; otherwise FETCH is held.
REQ-020 DECODE: one cycle; jump -> Jump=1, PCWrite=1, retire, next FETCH; illegal -> HALT with Err=01; all other opcodes -> EXEC.
REQ-021 EXEC: ALUSrc=1 for addi/ori/andi/lw/sw, else 0; ExtOp=1 for lw/sw/beq/bgt; AluOp = R:4, addi/lw/sw:2, ori:1, andi:0, beq/bgt:3.
REQ-022 EXEC beq: BranchEq=1, PCWrite=Zero, retire, next FETCH; bgt: BranchGr=1, PCWrite=Greater, retire, next FETCH.
REQ-023 EXEC R/addi/ori/andi -> WB; lw/sw -> MEM.
REQ-024 MEM: IorD=1, ALUSrc=1, ExtOp=1, AluOp=2; lw MemRead=1, sw MemWrite=1; held until MemReady=1; then lw -> WB, sw retires -> FETCH.
REQ-025 WB: RegWrite=1; RegDst=1 for R-type, else 0; MemToReg=1 for lw, else 0; ALU controls held at EXEC values; retire; next FETCH.
REQ-026 The wait counter SHALL clear on entry to FETCH/MEM; if MemReady stays 0 for MEM_TIMEOUT consecutive cycles, next state is HALT with Err=10 (FETCH) or 11 (MEM); MemReady on the final allowed cycle is accepted.
REQ-027 HALT: Halted=1, Err held, all strobes 0; exit only via rst.
REQ-028 InstrCount SHALL increment by 1 on every retire and wrap FFFF -> 0000; halted instructions do not retire.
REQ-029 Zero/Greater SHALL be ignored outside EXEC of beq/bgt.

Reset
REQ-030 rst=1 SHALL immediately force State=IDLE, all strobes 0, Halted=0, Err=00, InstrCount=0, latched opcode=0, wait counter=0, irrespective of clk.
REQ-031 rst asserted mid-instruction (including a pending MEM write) SHALL abort it without retiring; after release, operation restarts at IDLE.

Verification
REQ-032 R-type, MemReady=1 immediately: states 1,2,3,5,1; RegDst=1 and RegWrite=1 only in WB; InstrCount 0->1.
REQ-033 lw with MemReady delayed 3 cycles in MEM: MEM held 4 cycles with MemRead=1, IorD=1; WB has MemToReg=1; InstrCount +1.
REQ-034 beq Zero=0 then beq Zero=1: PCWrite=0 then 1 in EXEC; both retire; no WB visited.
REQ-035 OpCode=001001: HALT after DECODE, Halted=1, Err=01, InstrCount unchanged; MemReady pulses have no effect.
REQ-036 MemReady held 0 in FETCH: HALT after exactly 16 cycles, Err=10; rst pulse mid-wait -> IDLE asynchronously, Err=00.
REQ-037 Preload InstrCount to FFFF via 65535 jumps: next retire -> 0000.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake timeouts, halt-on-error and a retired-instruction counter.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OpCode,
    input  logic        Zero,
    input  logic        Greater,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        BranchEq,
    output logic        BranchGr,
    output logic        Jump,
    output logic        ExtOp,
    output logic [2:0]  AluOp,
    output logic        Halted,
    output logic [1:0]  Err,
    output logic [15:0] InstrCount,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_ORI  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_LW   = 6'd4;
    localparam logic [5:0] OP_SW   = 6'd5;
    localparam logic [5:0] OP_BEQ  = 6'd6;
    localparam logic [5:0] OP_BGT  = 6'd7;
    localparam logic [5:0] OP_JMP  = 6'd8;

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [5:0]     op_q, op_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [1:0]     err_q, err_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           retire;

    logic           ex_alusrc;
    logic           ex_extop;
    logic [2:0]     ex_aluop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ALU controls shared by EXEC and WB, taken from the latched opcode
    always_comb begin
        ex_alusrc = 1'b0;
        ex_extop  = 1'b0;
        ex_aluop  = 3'd0;
        case (op_q)
            OP_R:    ex_aluop = 3'd4;
            OP_ADDI: begin ex_alusrc = 1'b1; ex_aluop = 3'd2; end
            OP_ORI:  begin ex_alusrc = 1'b1; ex_aluop = 3'd1; end
            OP_ANDI: begin ex_alusrc = 1'b1; ex_aluop = 3'd0; end
            OP_LW, OP_SW: begin
                ex_alusrc = 1'b1;
                ex_extop  = 1'b1;
                ex_aluop  = 3'd2;
            end
            OP_BEQ, OP_BGT: begin
                ex_extop = 1'b1;
                ex_aluop = 3'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wait_d   = '0;
        err_d    = err_q;
        retire   = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        BranchEq = 1'b0;
        BranchGr = 1'b0;
        Jump     = 1'b0;
        ExtOp    = 1'b0;
        AluOp    = 3'd0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                AluOp   = 3'd2;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WLAST) begin
                    state_d = S_HALT;
                    err_d   = 2'b10;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: begin
                op_d = OpCode;
                if (OpCode == OP_JMP) begin
                    Jump    = 1'b1;
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (OpCode > OP_JMP) begin
                    state_d = S_HALT;
                    err_d   = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrc = ex_alusrc;
                ExtOp  = ex_extop;
                AluOp  = ex_aluop;
                case (op_q)
                    OP_BEQ: begin
                        BranchEq = 1'b1;
                        PCWrite  = Zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_BGT: begin
                        BranchGr = 1'b1;
                        PCWrite  = Greater;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                ALUSrc   = 1'b1;
                ExtOp    = 1'b1;
                AluOp    = 3'd2;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
                if (MemReady) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WLAST) begin
                    state_d = S_HALT;
                    err_d   = 2'b11;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_R);
                MemToReg = (op_q == OP_LW);
                ALUSrc   = ex_alusrc;
                ExtOp    = ex_extop;
                AluOp    = ex_aluop;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_d      = retire ? cnt_q + 16'd1 : cnt_q;
    assign Halted     = (state_q == S_HALT);
    assign Err        = err_q;
    assign InstrCount = cnt_q;
    assign State      = state_q;

endmodule
